// File: rtl/pc_seq_ctrl_if.sv
// Instruction-fetch handshake between the PC sequencer and instruction memory.
//   imem_req  : fetch request, driven by the sequencer (master)
//   imem_addr : fetch address, driven by the sequencer (master)
//   imem_ack  : instruction word available this cycle, driven by memory (slave)
interface pc_seq_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// PC sequencer: fetch/execute control with PC update, retired-instruction count
// and an optional misaligned-target trap.
//
// Build option: define FETCH_MISALIGN_TRAP_EN to enable the misaligned-target trap.
// Without it, trap/trap_pc are tied low and the PC is force-aligned on update.
//
// Ports:
//   clk, rstn    : clock, synchronous active-low reset
//   PCSrc, IMM   : next-PC operation and PC-relative immediate of the executing instruction
//   retire/stall : instruction completes / hold current instruction (EXEC only)
//   imem         : fetch handshake (master side: req, addr out; ack in)
//   PC           : PC of the current instruction
//   inst_valid   : fetched instruction held for execution
//   trap/trap_pc : one-cycle misaligned-target pulse and faulting target
//   instret      : retired-instruction count

`ifndef NPC_PLUS4
`define NPC_PLUS4  3'b000
`endif
`ifndef NPC_BRANCH
`define NPC_BRANCH 3'b001
`endif
`ifndef NPC_JUMP
`define NPC_JUMP   3'b010
`endif

module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [2:0]           PCSrc,
  input  logic [31:0]          IMM,
  input  logic                 retire,
  input  logic                 stall,
  pc_seq_ctrl_if.master        imem,
  output logic [31:0]          PC,
  output logic                 inst_valid,
  output logic                 trap,
  output logic [31:0]          trap_pc,
  output logic [31:0]          instret
);

  typedef enum logic [1:0] {StFetch, StExec, StTrap} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] instret_q;
  logic [31:0] pc_offset;
  logic [31:0] next_pc;
  logic        retire_fire;

  // Stall wins over retire; a stalled retire is simply dropped.
  assign retire_fire = (state_q == StExec) && retire && !stall;

  always_comb begin
    case (PCSrc)
      `NPC_BRANCH, `NPC_JUMP: pc_offset = IMM;
      default:                pc_offset = 32'd4;
    endcase
  end

  assign next_pc = pc_q + pc_offset;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned;
  logic [31:0] trap_pc_q;
  assign misaligned = |next_pc[1:0];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (imem.imem_ack) state_d = StExec;
      end
      StExec: begin
        if (retire_fire) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          state_d = misaligned ? StTrap : StFetch;
`else
          state_d = StFetch;
`endif
        end
      end
      StTrap:  state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // Output decode; imem_req is also gated by rstn so it stays low throughout reset
  always_comb begin
    imem.imem_req = 1'b0;
    inst_valid    = 1'b0;
    trap          = 1'b0;
    unique case (state_q)
      StFetch: imem.imem_req = rstn;
      StExec:  inst_valid    = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      StTrap:  trap          = 1'b1;
`else
      StTrap:  trap          = 1'b0;
`endif
      default: ;
    endcase
  end

  assign imem.imem_addr = pc_q;
  assign PC             = pc_q;
  assign instret        = instret_q;

  // PC and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q      <= RESET_PC;
      instret_q <= '0;
    end else begin
      if (retire_fire) begin
        instret_q <= instret_q + 32'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
        // A misaligned target leaves PC alone; TRAP_VEC is loaded on trap exit.
        if (!misaligned) pc_q <= next_pc;
`else
        pc_q <= next_pc & 32'hFFFF_FFFC;
`endif
      end
      if (state_q == StTrap) pc_q <= TRAP_VEC;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      trap_pc_q <= '0;
    end else if (retire_fire && misaligned) begin
      trap_pc_q <= next_pc;
    end
  end
  assign trap_pc = trap_pc_q;
`else
  assign trap_pc = '0;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed vector table plus hand-written
// reset-abandon sequence. Expectations follow the FETCH_MISALIGN_TRAP_EN build option.

`ifndef NPC_PLUS4
`define NPC_PLUS4  3'b000
`endif
`ifndef NPC_BRANCH
`define NPC_BRANCH 3'b001
`endif
`ifndef NPC_JUMP
`define NPC_JUMP   3'b010
`endif

module tb_pc_seq_ctrl;

  logic        clk;
  logic        rstn;
  logic [2:0]  pcsrc;
  logic [31:0] imm;
  logic        retire;
  logic        stall;
  logic [31:0] pc;
  logic        inst_valid;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] instret;

  pc_seq_ctrl_if imem_bus ();

  pc_seq_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .PCSrc      (pcsrc),
    .IMM        (imm),
    .retire     (retire),
    .stall      (stall),
    .imem       (imem_bus),
    .PC         (pc),
    .inst_valid (inst_valid),
    .trap       (trap),
    .trap_pc    (trap_pc),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic [2:0]  src;
    logic [31:0] im;
    logic        rt;
    logic        st;
    logic        ak;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        e_trap;
    logic [31:0] e_instret;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic rn, logic [2:0] src, logic [31:0] im, logic rt, logic st,
                              logic ak, logic e_req, logic [31:0] e_addr, logic e_valid,
                              logic e_trap, logic [31:0] e_instret);
    vec_t r;
    r.rn = rn; r.src = src; r.im = im; r.rt = rt; r.st = st; r.ak = ak;
    r.e_req = e_req; r.e_addr = e_addr; r.e_valid = e_valid; r.e_trap = e_trap;
    r.e_instret = e_instret;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic [2:0] src, input logic [31:0] im,
                       input logic rt, input logic st, input logic ak);
    rstn = rn; pcsrc = src; imm = im; retire = rt; stall = st; imem_bus.imem_ack = ak;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; pcsrc = `NPC_PLUS4; imm = '0; retire = 1'b0; stall = 1'b0;
    imem_bus.imem_ack = 1'b0;
    step();

    //             rn src          imm           rt st ak  req addr          vld trp instret
    vecs.push_back(mk(0, `NPC_PLUS4,  32'h0,         0, 0, 0,  0, 32'h0,         0, 0, 0));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         0, 0, 1,  1, 32'h0,         0, 0, 0));
    vecs.push_back(mk(1, `NPC_JUMP,   32'h100,       1, 0, 0,  0, 32'h0,         1, 0, 0));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         0, 0, 0,  1, 32'h100,       0, 0, 1));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         0, 0, 1,  1, 32'h100,       0, 0, 1));
    vecs.push_back(mk(1, `NPC_BRANCH, 32'hFFFF_FFF0, 1, 0, 0,  0, 32'h100,       1, 0, 1));
    // retire in FETCH must be ignored
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         1, 0, 0,  1, 32'hF0,        0, 0, 2));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         1, 0, 1,  1, 32'hF0,        0, 0, 2));
    // stall holds retire for three cycles
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         1, 1, 0,  0, 32'hF0,        1, 0, 2));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         1, 1, 0,  0, 32'hF0,        1, 0, 2));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         1, 1, 0,  0, 32'hF0,        1, 0, 2));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         1, 0, 0,  0, 32'hF0,        1, 0, 2));
    // five cycles without ack
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         0, 0, 0,  1, 32'hF4,        0, 0, 3));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         0, 0, 0,  1, 32'hF4,        0, 0, 3));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         0, 0, 0,  1, 32'hF4,        0, 0, 3));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         0, 0, 0,  1, 32'hF4,        0, 0, 3));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         0, 0, 0,  1, 32'hF4,        0, 0, 3));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         0, 0, 1,  1, 32'hF4,        0, 0, 3));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         0, 0, 0,  0, 32'hF4,        1, 0, 3));
    // unknown encoding behaves as +4; ack ignored in EXEC
    vecs.push_back(mk(1, 3'b101,      32'h40,        1, 0, 1,  0, 32'hF4,        1, 0, 3));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         0, 0, 1,  1, 32'hF8,        0, 0, 4));
    vecs.push_back(mk(1, `NPC_JUMP,   32'hFFFF_FF04, 1, 0, 0,  0, 32'hF8,        1, 0, 4));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         0, 0, 1,  1, 32'hFFFF_FFFC, 0, 0, 5));
    // wrap of PC+4
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         1, 0, 0,  0, 32'hFFFF_FFFC, 1, 0, 5));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         0, 0, 1,  1, 32'h0,         0, 0, 6));
    vecs.push_back(mk(1, `NPC_JUMP,   32'h200,       1, 0, 0,  0, 32'h0,         1, 0, 6));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         0, 0, 1,  1, 32'h200,       0, 0, 7));
    vecs.push_back(mk(1, `NPC_JUMP,   32'h6,         1, 0, 0,  0, 32'h200,       1, 0, 7));
`ifdef FETCH_MISALIGN_TRAP_EN
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         1, 0, 1,  0, 32'h200,       0, 1, 8));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         0, 0, 0,  1, 32'h100,       0, 0, 8));
`else
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         0, 0, 0,  1, 32'h204,       0, 0, 8));
    vecs.push_back(mk(1, `NPC_PLUS4,  32'h0,         0, 0, 1,  1, 32'h204,       0, 0, 8));
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].rn, vecs[i].src, vecs[i].im, vecs[i].rt, vecs[i].st, vecs[i].ak);
      check($sformatf("v%0d imem_req", i),   {31'd0, imem_bus.imem_req}, {31'd0, vecs[i].e_req});
      check($sformatf("v%0d imem_addr", i),  imem_bus.imem_addr,         vecs[i].e_addr);
      check($sformatf("v%0d inst_valid", i), {31'd0, inst_valid},        {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d trap", i),       {31'd0, trap},              {31'd0, vecs[i].e_trap});
      check($sformatf("v%0d instret", i),    instret,                    vecs[i].e_instret);
      step();
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    check("trap_pc", trap_pc, 32'h206);
`else
    check("trap_pc tied", trap_pc, 32'h0);
`endif

    // Reach EXEC from either end state, then reset mid-execute with a late ack.
    drive(1, `NPC_PLUS4, 32'h0, 0, 0, 1);
    step();
    drive(1, `NPC_PLUS4, 32'h0, 0, 0, 0);
    check("pre-reset inst_valid", {31'd0, inst_valid}, 32'd1);
    step();
    drive(0, `NPC_PLUS4, 32'h0, 1, 0, 1);
    check("reset imem_req low", {31'd0, imem_bus.imem_req}, 32'd0);
    step();
    drive(0, `NPC_PLUS4, 32'h0, 0, 0, 1);
    check("reset2 imem_req low", {31'd0, imem_bus.imem_req}, 32'd0);
    check("reset inst_valid", {31'd0, inst_valid}, 32'd0);
    check("reset PC", pc, 32'h0);
    check("reset instret", instret, 32'h0);
    check("reset trap_pc", trap_pc, 32'h0);
    step();
    drive(1, `NPC_PLUS4, 32'h0, 0, 0, 0);
    check("release imem_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check("release imem_addr", imem_bus.imem_addr, 32'h0);
    step();
    drive(1, `NPC_PLUS4, 32'h0, 0, 0, 0);
    check("late ack ignored", {31'd0, inst_valid}, 32'd0);
    check("still fetching", {31'd0, imem_bus.imem_req}, 32'd1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter TRAP_VEC, default 32'h0000_0100, meaning the redirect target on a misaligned-target trap.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port PCSrc, input, 3 bits: next-PC operation of the executing instruction, using the shared `NPC_PLUS4/`NPC_BRANCH/`NPC_JUMP encodings.
REQ-006 Port IMM, input, 32 bits: PC-relative immediate of the executing instruction.
REQ-007 Port retire, input, 1 bit: the executing instruction completes this cycle.
REQ-008 Port stall, input, 1 bit: hold the current instruction.
REQ-009 Port imem_req, output, 1 bit: instruction fetch request.
REQ-010 Port imem_addr, output, 32 bits: fetch address.
REQ-011 Port imem_ack, input, 1 bit: the instruction word is available this cycle.
REQ-012 Port PC, output, 32 bits: PC of the current instruction.
REQ-013 Port inst_valid, output, 1 bit: the fetched instruction is held for execution.
REQ-014 Port trap, output, 1 bit: one-cycle misaligned-target pulse.
REQ-015 Port trap_pc, output, 32 bits: the faulting target address.
REQ-016 Port instret, output, 32 bits: retired-instruction count.

Function
REQ-017 The FSM SHALL have three states: FETCH, EXEC and TRAP; all outputs are registered or decoded from state only.
REQ-018 In FETCH: imem_req=1, imem_addr=PC, inst_valid=0; imem_addr stays stable until ack; imem_ack=1 -> EXEC on the next edge.
REQ-019 In EXEC: inst_valid=1, imem_req=0.
REQ-020 In EXEC with retire=1 and stall=0, the next PC SHALL be selected per PCSrc:
- `NPC_PLUS4 -> PC+4;
- `NPC_BRANCH -> PC+IMM;
- `NPC_JUMP -> PC+IMM;
- any other encoding -> PC+4.
REQ-021 On that retire, PC SHALL be loaded with the next PC, instret SHALL be incremented and the FSM SHALL go to FETCH.
REQ-022 stall=1 SHALL take priority over retire: no PC, state or instret change, and the retire is dropped (the source must re-assert it).
REQ-023 retire and stall SHALL be ignored outside EXEC; imem_ack SHALL be ignored outside FETCH.
REQ-024 All address arithmetic SHALL be modulo 2^32 (PC=32'hFFFF_FFFC with PLUS4 -> 32'h0000_0000); instret SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-025 Minimum loop latency SHALL be 2 cycles per instruction: FETCH with an immediate ack, then EXEC with an immediate retire.
REQ-026 trap SHALL be 0 and trap_pc SHALL hold its last value except as stated in REQ-032.

Reset
REQ-027 While rstn=0 at a clock edge: state=FETCH, PC=RESET_PC, instret=0, trap=0, trap_pc=0, inst_valid=0.
REQ-028 imem_req SHALL be 0 in any cycle where rstn=0; it asserts in the first cycle after release.
REQ-029 Reset mid-fetch or mid-execute SHALL abandon the operation; a late imem_ack is ignored until FETCH is re-entered.

Configuration
REQ-030 Macro FETCH_MISALIGN_TRAP_EN SHALL gate the misaligned-target trap.
REQ-031 Without the macro: the trap and trap_pc outputs SHALL be tied 0, TRAP is unreachable, and PC is loaded with {next[31:2],2'b00}.
REQ-032 With the macro: a retire whose next-PC bits [1:0] are nonzero SHALL enter TRAP instead of FETCH, with:
- trap=1 for exactly one cycle while in TRAP;
- trap_pc=unaligned next PC;
- instret incremented;
- PC=TRAP_VEC on TRAP exit;
- return to FETCH.

Verification
REQ-033 Reset release with RESET_PC=0 and ack the same cycle -> imem_req=1 and imem_addr=0 in cycle 1, inst_valid=1 in cycle 2.
REQ-034 PC=0x100 with `NPC_BRANCH, IMM=0xFFFF_FFF0 and retire -> next imem_addr=0xF0, instret+1.
REQ-035 In EXEC, retire=1 and stall=1 for 3 cycles, then a retire with stall=0 -> PC unchanged for 3 cycles, a single instret increment, then FETCH.
REQ-036 Hold imem_ack=0 for 5 cycles in FETCH -> imem_req and imem_addr stable for all 5 cycles, inst_valid=0.
REQ-037 PC=0xFFFF_FFFC with `NPC_PLUS4 and retire -> imem_addr=0x0.
REQ-038 With the macro: PC=0x200, `NPC_JUMP, IMM=0x6 -> trap pulse of 1 cycle, trap_pc=0x206, next imem_addr=0x100; without the macro: imem_addr=0x204 and trap=0.
